// File: rtl/vending_machine_gen2.sv
// vending_machine_gen2: two-coin vending controller with greedy change
// dispensing, refund-on-shortage and exported safety properties.
// Optional feature macro: VENDING_REFILL_EN adds refillHi/refillLo inputs
// that top up the inventory while idle.
module vending_machine_gen2 #(
  parameter int unsigned COIN_W   = 2,
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned VAL_W    = 8,
  parameter int unsigned VALUE_HI = 5,
  parameter int unsigned VALUE_LO = 1,
  parameter int unsigned COST_1   = 2,
  parameter int unsigned COST_2   = 6,
  parameter int unsigned COST_3   = 12,
  parameter int unsigned INIT_HI  = 2,
  parameter int unsigned INIT_LO  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COIN_W-1:0] coinInHi,
  input  logic [COIN_W-1:0] coinInLo,
  input  logic [1:0]        itemTypeIn,
`ifdef VENDING_REFILL_EN
  input  logic [CNT_W-1:0]  refillHi,
  input  logic [CNT_W-1:0]  refillLo,
`endif
  output logic [COIN_W-1:0] coinOutHi,
  output logic [COIN_W-1:0] coinOutLo,
  output logic [1:0]        itemTypeOut,
  output logic [1:0]        serviceTypeOut,
  output logic              p_uninit,
  output logic              p_change
);

  // Sum width large enough for any counter plus any coin/refill increment.
  localparam int unsigned SUM_W = ((CNT_W > COIN_W) ? CNT_W : COIN_W) + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [COIN_W-1:0] COIN_MAX = '1;

  typedef enum logic [1:0] {
    SVC_OFF  = 2'b00,
    SVC_ON   = 2'b01,
    SVC_BUSY = 2'b10
  } service_t;

  typedef enum logic [1:0] {
    PH_CHECK  = 2'd0,
    PH_HI     = 2'd1,
    PH_LO     = 2'd2,
    PH_REFUND = 2'd3
  } phase_t;

  service_t          serviceState;
  phase_t            phase;
  logic              initialized;
  logic [CNT_W-1:0]  invHi;
  logic [CNT_W-1:0]  invLo;
  logic [COIN_W-1:0] depHi;
  logic [COIN_W-1:0] depLo;
  logic [VAL_W-1:0]  inputValue;
  logic [VAL_W-1:0]  serviceValue;
  logic [VAL_W-1:0]  exchange;

  // Price lookup; item 0 costs nothing.
  function automatic logic [VAL_W-1:0] costOf(input logic [1:0] item);
    case (item)
      2'd1:    costOf = VAL_W'(COST_1);
      2'd2:    costOf = VAL_W'(COST_2);
      2'd3:    costOf = VAL_W'(COST_3);
      default: costOf = '0;
    endcase
  endfunction

  // Inventory add that saturates at the counter maximum.
  function automatic logic [CNT_W-1:0] invAdd(input logic [CNT_W-1:0] cnt,
                                              input logic [SUM_W-1:0] add);
    logic [SUM_W-1:0] s;
    s = SUM_W'(cnt) + add;
    invAdd = (s > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(s);
  endfunction

  // Inventory subtract floored at zero.
  function automatic logic [CNT_W-1:0] invSub(input logic [CNT_W-1:0] cnt,
                                              input logic [SUM_W-1:0] sub);
    invSub = (SUM_W'(cnt) > sub) ? CNT_W'(SUM_W'(cnt) - sub) : '0;
  endfunction

  // Dispensed-coin counter increment that saturates.
  function automatic logic [COIN_W-1:0] coinInc(input logic [COIN_W-1:0] c);
    coinInc = (c == COIN_MAX) ? c : c + COIN_W'(1);
  endfunction

  // Controller FSM: request capture, change computation, dispensing, refund.
  always_ff @(posedge clk) begin
    if (!reset) begin
      coinOutHi    <= '0;
      coinOutLo    <= '0;
      itemTypeOut  <= '0;
      serviceState <= SVC_ON;
      phase        <= PH_CHECK;
      invHi        <= CNT_W'(INIT_HI);
      invLo        <= CNT_W'(INIT_LO);
      depHi        <= '0;
      depLo        <= '0;
      inputValue   <= '0;
      serviceValue <= '0;
      initialized  <= 1'b1;
    end else if (initialized) begin
      case (serviceState)
        SVC_ON: begin
          if (itemTypeIn != 2'd0) begin
            depHi        <= coinInHi;
            depLo        <= coinInLo;
            inputValue   <= VAL_W'(VALUE_HI) * VAL_W'(coinInHi)
                          + VAL_W'(VALUE_LO) * VAL_W'(coinInLo);
            serviceValue <= costOf(itemTypeIn);
            itemTypeOut  <= itemTypeIn;
            coinOutHi    <= '0;
            coinOutLo    <= '0;
            invHi        <= invAdd(invHi, SUM_W'(coinInHi));
            invLo        <= invAdd(invLo, SUM_W'(coinInLo));
            serviceState <= SVC_BUSY;
            phase        <= PH_CHECK;
          end
`ifdef VENDING_REFILL_EN
          else begin
            invHi <= invAdd(invHi, SUM_W'(refillHi));
            invLo <= invAdd(invLo, SUM_W'(refillLo));
          end
`endif
        end
        SVC_BUSY: begin
          case (phase)
            PH_CHECK: begin
              if (inputValue < serviceValue) begin
                itemTypeOut  <= '0;
                serviceValue <= inputValue;
              end else begin
                serviceValue <= inputValue - serviceValue;
              end
              phase <= PH_HI;
            end
            PH_HI: begin
              if ((serviceValue >= VAL_W'(VALUE_HI)) && (invHi != '0)) begin
                coinOutHi    <= coinInc(coinOutHi);
                invHi        <= invHi - CNT_W'(1);
                serviceValue <= serviceValue - VAL_W'(VALUE_HI);
              end else begin
                phase <= PH_LO;
              end
            end
            PH_LO: begin
              if (serviceValue == '0) begin
                serviceState <= SVC_OFF;
              end else if (invLo != '0) begin
                coinOutLo    <= coinInc(coinOutLo);
                invLo        <= invLo - CNT_W'(1);
                serviceValue <= serviceValue - VAL_W'(VALUE_LO);
              end else begin
                phase <= PH_REFUND;
              end
            end
            default: begin
              // Out of change: put dispensed coins back, hand back the deposit.
              invHi        <= invSub(invAdd(invHi, SUM_W'(coinOutHi)), SUM_W'(depHi));
              invLo        <= invSub(invAdd(invLo, SUM_W'(coinOutLo)), SUM_W'(depLo));
              coinOutHi    <= depHi;
              coinOutLo    <= depLo;
              itemTypeOut  <= '0;
              serviceValue <= inputValue;
              serviceState <= SVC_OFF;
            end
          endcase
        end
        SVC_OFF: begin
          coinOutHi    <= '0;
          coinOutLo    <= '0;
          itemTypeOut  <= '0;
          serviceState <= SVC_ON;
          phase        <= PH_CHECK;
        end
        default: begin
          serviceState <= SVC_ON;
          phase        <= PH_CHECK;
        end
      endcase
    end
  end

  assign serviceTypeOut = serviceState;

  // Safety properties for the model checker (1 = violation).
  assign exchange = VAL_W'(VALUE_HI) * VAL_W'(coinOutHi)
                  + VAL_W'(VALUE_LO) * VAL_W'(coinOutLo);
  assign p_uninit = !initialized && ((coinOutHi != '0) || (coinOutLo != '0) ||
                                     (itemTypeOut != '0) || (serviceTypeOut != '0));
  assign p_change = initialized && (serviceState == SVC_OFF) &&
                    (exchange != (inputValue - costOf(itemTypeOut)));

endmodule

// File: tb/tb_vending_machine_gen2.sv
// tb_vending_machine_gen2: directed and randomized transactions checked
// against a transaction-level model of the vending rules.
module tb_vending_machine_gen2;

  localparam int COIN_W   = 2;
  localparam int CNT_W    = 3;
  localparam int VAL_W    = 8;
  localparam int VALUE_HI = 5;
  localparam int VALUE_LO = 1;
  localparam int COST_1   = 2;
  localparam int COST_2   = 6;
  localparam int COST_3   = 12;
  localparam int INIT_HI  = 2;
  localparam int INIT_LO  = 2;
  localparam int CNT_MAXI  = (1 << CNT_W) - 1;
  localparam int COIN_MAXI = (1 << COIN_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [COIN_W-1:0] coinInHi, coinInLo;
  logic [1:0]        itemTypeIn;
  logic [COIN_W-1:0] coinOutHi, coinOutLo;
  logic [1:0]        itemTypeOut, serviceTypeOut;
  logic              p_uninit, p_change;
`ifdef VENDING_REFILL_EN
  logic [CNT_W-1:0]  refillHi, refillLo;
`endif

  int nCmp  = 0;
  int nFail = 0;
  int mInvHi, mInvLo;

  always #5 clk = ~clk;

  vending_machine_gen2 #(
    .COIN_W(COIN_W), .CNT_W(CNT_W), .VAL_W(VAL_W),
    .VALUE_HI(VALUE_HI), .VALUE_LO(VALUE_LO),
    .COST_1(COST_1), .COST_2(COST_2), .COST_3(COST_3),
    .INIT_HI(INIT_HI), .INIT_LO(INIT_LO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .coinInHi(coinInHi),
    .coinInLo(coinInLo),
    .itemTypeIn(itemTypeIn),
`ifdef VENDING_REFILL_EN
    .refillHi(refillHi),
    .refillLo(refillLo),
`endif
    .coinOutHi(coinOutHi),
    .coinOutLo(coinOutLo),
    .itemTypeOut(itemTypeOut),
    .serviceTypeOut(serviceTypeOut),
    .p_uninit(p_uninit),
    .p_change(p_change)
  );

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int price(input int item);
    case (item)
      1:       return COST_1;
      2:       return COST_2;
      3:       return COST_3;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Transaction-level model: value, greedy change, refund, latency, outputs.
  task automatic modelTxn(input int h, input int l, input int item,
                          output int eItem, output int eHi, output int eLo,
                          output int eLat, output int ePch);
    int value, change, nHi, nLo, exch;
    bit refund;
    value  = VALUE_HI * h + VALUE_LO * l;
    mInvHi = imin(CNT_MAXI, mInvHi + h);
    mInvLo = imin(CNT_MAXI, mInvLo + l);
    if (value < price(item)) begin
      eItem  = 0;
      change = value;
    end else begin
      eItem  = item;
      change = value - price(item);
    end
    nHi = 0;
    while (change >= VALUE_HI && mInvHi > 0) begin
      nHi++; mInvHi--; change -= VALUE_HI;
    end
    nLo = 0;
    refund = 1'b0;
    while (change > 0 && !refund) begin
      if (mInvLo == 0) refund = 1'b1;
      else begin
        nLo++; mInvLo--; change -= VALUE_LO;
      end
    end
    eHi = imin(nHi, COIN_MAXI);
    eLo = imin(nLo, COIN_MAXI);
    if (refund) begin
      mInvHi = imax(0, imin(CNT_MAXI, mInvHi + eHi) - h);
      mInvLo = imax(0, imin(CNT_MAXI, mInvLo + eLo) - l);
      eHi = h; eLo = l; eItem = 0;
    end
    eLat = 4 + nHi + nLo + (refund ? 1 : 0);
    exch = VALUE_HI * eHi + VALUE_LO * eLo;
    ePch = (exch != value - price(eItem)) ? 1 : 0;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_svc"}, 32'(serviceTypeOut), 32'd1);
    check({tag, "_hi"}, 32'(coinOutHi), 32'd0);
    check({tag, "_lo"}, 32'(coinOutLo), 32'd0);
    check({tag, "_item"}, 32'(itemTypeOut), 32'd0);
    check({tag, "_puninit"}, 32'(p_uninit), 32'd0);
    check({tag, "_pchange"}, 32'(p_change), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0; itemTypeIn = '0; coinInHi = '0; coinInLo = '0;
    @(negedge clk);
    checkIdle("reset");
    reset = 1'b1;
    mInvHi = INIT_HI;
    mInvLo = INIT_LO;
  endtask

  // Issue one request, scramble inputs while busy, check the OFF cycle.
  task automatic request(input string tag, input int h, input int l, input int item);
    int eItem, eHi, eLo, eLat, ePch, n;
    modelTxn(h, l, item, eItem, eHi, eLo, eLat, ePch);
    @(negedge clk);
    coinInHi = COIN_W'(h); coinInLo = COIN_W'(l); itemTypeIn = 2'(item);
    @(negedge clk);
    n = 1;
    check({tag, "_busy"}, 32'(serviceTypeOut), 32'd2);
    while (serviceTypeOut !== 2'b00 && n < 64) begin
      check({tag, "_pchange_busy"}, 32'(p_change), 32'd0);
      check({tag, "_puninit_busy"}, 32'(p_uninit), 32'd0);
      coinInHi   = COIN_W'($urandom_range(0, COIN_MAXI));
      coinInLo   = COIN_W'($urandom_range(0, COIN_MAXI));
      itemTypeIn = 2'($urandom_range(0, 3));
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(eLat));
    check({tag, "_item"}, 32'(itemTypeOut), 32'(eItem));
    check({tag, "_coinHi"}, 32'(coinOutHi), 32'(eHi));
    check({tag, "_coinLo"}, 32'(coinOutLo), 32'(eLo));
    check({tag, "_pchange"}, 32'(p_change), 32'(ePch));
    check({tag, "_puninit"}, 32'(p_uninit), 32'd0);
    @(negedge clk);
    coinInHi = '0; coinInLo = '0; itemTypeIn = '0;
    checkIdle({tag, "_after"});
  endtask

  // Idle cycles with stray coins but no item: nothing may change.
  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      coinInHi   = COIN_W'($urandom_range(0, COIN_MAXI));
      coinInLo   = COIN_W'($urandom_range(0, COIN_MAXI));
      itemTypeIn = '0;
      @(negedge clk);
      checkIdle("idle");
    end
    coinInHi = '0; coinInLo = '0;
  endtask

`ifdef VENDING_REFILL_EN
  task automatic refill(input int h, input int l);
    @(negedge clk);
    refillHi = CNT_W'(h); refillLo = CNT_W'(l); itemTypeIn = '0;
    @(negedge clk);
    refillHi = '0; refillLo = '0;
    mInvHi = imin(CNT_MAXI, mInvHi + h);
    mInvLo = imin(CNT_MAXI, mInvLo + l);
    checkIdle("refill");
  endtask
`endif

  initial begin
    reset = 1'b0; coinInHi = '0; coinInLo = '0; itemTypeIn = '0;
`ifdef VENDING_REFILL_EN
    refillHi = '0; refillLo = '0;
`endif
    mInvHi = INIT_HI;
    mInvLo = INIT_LO;

    doReset();
    request("exact_item2", 1, 1, 2);
    doReset();
    request("refund_item1", 1, 0, 1);
    doReset();
    request("short_item3", 1, 2, 3);
    doReset();
    request("change_item2", 2, 2, 2);
    doReset();

    // Reset while dispensing the high coin: deposit discarded, INIT reloaded.
    @(negedge clk);
    coinInHi = 2'd2; coinInLo = 2'd2; itemTypeIn = 2'd2;
    @(negedge clk);
    coinInHi = '0; coinInLo = '0; itemTypeIn = '0;
    @(negedge clk);
    check("midrst_busy", 32'(serviceTypeOut), 32'd2);
    reset = 1'b0;
    @(negedge clk);
    checkIdle("midrst");
    reset = 1'b1;
    mInvHi = INIT_HI;
    mInvLo = INIT_LO;
    request("post_rst_item1", 1, 0, 1);
    request("valw_max", COIN_MAXI, COIN_MAXI, 1);
    idle(3);

`ifdef VENDING_REFILL_EN
    doReset();
    refill(0, 3);
    refill(0, 3);
    refill(0, 3);
    request("refill_item1", 1, 0, 1);
`endif

    for (int t = 0; t < 40; t++) begin
      request($sformatf("rnd%0d", t), int'($urandom_range(0, COIN_MAXI)),
              int'($urandom_range(0, COIN_MAXI)), int'($urandom_range(1, 3)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 7) == 0) doReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/vending_machine_gen2.md
# vending_machine_gen2

Parametrised second-generation vending controller for the SoCV formal-verification suite. It has two coin denominations with configurable values, up to three priced items, per-denomination inventory counters and a greedy change dispenser. When the dispenser runs out of change it restores the inventory and returns the exact deposited coins. It exports built-in safety-property outputs for the model checker (1 = violation).

## Interface
Parameters:
- COIN_W, 2: width of per-transaction coin inputs/outputs
- CNT_W, 3: inventory counter width; counters saturate at 2^CNT_W-1
- VAL_W, 8: width of all money values
- VALUE_HI, 5: value of the high coin
- VALUE_LO, 1: value of the low coin
- COST_1 / COST_2 / COST_3, 2 / 6 / 12: item prices
- INIT_HI / INIT_LO, 2 / 2: inventory loaded at reset

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-low reset
- coinInHi / coinInLo  in  COIN_W  coins deposited with a request
- itemTypeIn  in  2  requested item; 0 = none
- coinOutHi / coinOutLo  out  COIN_W  change coins being dispensed
- itemTypeOut  out  2  item being delivered
- serviceTypeOut  out  2  00 OFF (deliver), 01 ON (idle), 10 BUSY
- p_uninit  out  1  high when not initialized and any output is nonzero
- p_change  out  1  high when initialized, OFF, and exchange ≠ inputValue − cost(itemTypeOut)

## Operation
- Reset (reset == 0):
  - coinOut* = 0, itemTypeOut = 0, serviceTypeOut = ON.
  - Inventory = INIT_HI/INIT_LO; inputValue and serviceValue = 0.
  - Phase = CHECK; initialized = 1. initialized is never cleared afterwards.
  - Before the first reset the FSM holds its state.
- ON:
  - A request (itemTypeIn ≠ 0) latches depHi/depLo and computes inputValue = VALUE_HI·coinInHi + VALUE_LO·coinInLo at VAL_W.
  - It sets serviceValue = cost of the item, itemTypeOut = itemTypeIn, coinOut* = 0 and goes to BUSY/CHECK.
  - Deposits are added to the inventory, saturating. Coins beyond the saturation limit still count toward value.
  - itemTypeIn = 0 means no change of state.
- BUSY/CHECK (1 cycle):
  - If inputValue < cost: itemTypeOut = 0 and serviceValue = inputValue (full refund).
  - Otherwise serviceValue = inputValue − cost.
  - Next phase is HI.
- BUSY/HI:
  - If serviceValue ≥ VALUE_HI and invHi > 0: coinOutHi += 1, invHi −= 1, serviceValue −= VALUE_HI.
  - Otherwise go to LO (that cycle dispenses nothing).
- BUSY/LO:
  - serviceValue = 0: go to OFF.
  - invLo > 0: coinOutLo += 1, invLo −= 1, serviceValue −= VALUE_LO.
  - invLo == 0: go to REFUND.
- BUSY/REFUND (1 cycle):
  - Restore the inventory: inv += coinOut* (saturating).
  - Set coinOut* = depHi/depLo and inv −= dep (floored at 0).
  - itemTypeOut = 0, serviceValue = inputValue; go to OFF.
- OFF (1 cycle):
  - Outputs are valid and the properties are evaluated.
  - Next cycle: coinOut* = 0, itemTypeOut = 0, state ON, phase CHECK.
- Widths: coin counters in the dispense path are COIN_W and saturate. VAL_W must hold VALUE_HI·(2^COIN_W−1) + VALUE_LO·(2^COIN_W−1); the bench checks this.
- Properties:
  - exchange = VALUE_HI·coinOutHi + VALUE_LO·coinOutLo.
  - cost(0) = 0.
  - During REFUND, exchange = inputValue by construction.

## Timing
- Request sampled in cycle k: BUSY from k+1, HI from k+2.
- Each dispensed coin takes one cycle.
- The HI→LO transition and the LO→OFF decision each take one cycle.
- Exact-payment latency: k+1 CHECK, k+2 HI (no coin), k+3 LO, k+4 OFF, k+5 ON.
- Inputs are ignored outside ON; a request arriving during BUSY/OFF is dropped.
- Reset mid-transaction: next cycle returns to the reset state, discards the deposit and reloads INIT inventory.

## Configuration
- VENDING_REFILL_EN defined:
  - Adds ports refillHi / refillLo, input, CNT_W each.
  - In ON with itemTypeIn = 0, they are added to the inventory (saturating).
  - Ignored when a request is present or outside ON.
- VENDING_REFILL_EN undefined: ports absent; the inventory changes only through transactions and reset.

## Test plan
- Reset, item 2, Hi=1 Lo=1 (value 6) → cycle k+4: OFF, item 2, coinOut 0/0, p_change 0; inventory 3/3.
- Reset, item 1, Hi=1 Lo=0 (value 5, change 3, invLo 2) → two Lo coins, then REFUND → OFF, item 0, coinOutHi 1, coinOutLo 0; inventory 2/2.
- Reset, item 3, Hi=1 Lo=2 (value 7 < 12) → OFF, item 0, coinOut 1/2 (exchange 7), p_change 0.
- Reset, item 2, Hi=2 Lo=2 (value 12, change 6) → OFF, item 2, coinOut 1/1; inventory 3/3 (deposits 4/4 minus dispensed).
- Reset asserted during BUSY/HI → next cycle ON, all outputs 0, inventory 2/2; p_uninit and p_change stay 0 for the whole run.
- VENDING_REFILL_EN: refillLo = 3 in idle ON from 2/2 → invLo saturates at 7 only after repeated refills. Then repeat the item 1 Hi=1 request → change 3 as Lo×3, item 1, no refund.
